uart_tx_8n1: RTL

- Serial UART transmitter; the transmit-side counterpart of the team's 16x-oversampled 8N1 receiver.
- Accepts one byte per valid/ready handshake and shifts it out LSB first.
- Frame format: start bit (0), 8 data bits, stop bit (1).
- Bit timing uses the same tick/oversample scheme as the receiver, so both ends agree on baud from one parameter set.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_tx_8n1.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg: shared UART state encoding, baud defaults, frame sizes.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    localparam int CLKS_PER_TICK_DEF = 651;
    localparam int TICKS_PER_BIT_DEF = 16;

    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_baud_tick: one-cycle tick every CLKS_PER_TICK clocks.          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW     = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_8n1.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_8n1: 16x-tick UART transmitter, 8N1 (8E1 with              |
// | UART_TX_PARITY_EN defined).  Revision: 1.0                          |
// +--------------------------------------------------------------------+
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEF,
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF,
    parameter int DATA_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam int TIW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BIW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_STOP   = STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = PARITY;
`endif

    localparam logic [TIW-1:0] C_TICK_LAST = TIW'(TICKS_PER_BIT - 1);
    localparam logic [BIW-1:0] C_BIT_LAST  = BIW'(DATA_BITS - 1);

    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [TIW-1:0]       r_tick_idx;
    logic [BIW-1:0]       r_bit_idx;
    logic                 r_tx_out;
    logic                 r_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_tick;
    logic w_accept;
    logic w_bit_end;

    assign w_accept  = tx_valid && (r_state == ST_IDLE);
    assign w_bit_end = w_tick && (r_tick_idx == C_TICK_LAST);

    uart_baud_tick #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (w_accept),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_tick_idx <= '0;
            r_bit_idx  <= '0;
            r_tx_out   <= 1'b1;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_tick) begin
                r_tick_idx <= (r_tick_idx == C_TICK_LAST) ? '0 : r_tick_idx + TIW'(1);
            end

            // tx_out is loaded together with each state change so the new
            // level appears in the first cycle of the new state.
            case (r_state)
                ST_IDLE: begin
                    r_tx_out <= 1'b1;
                    if (tx_valid) begin
                        r_state    <= ST_START;
                        r_tx_out   <= 1'b0;
                        r_shift    <= tx_data;
                        r_tick_idx <= '0;
                        r_bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^tx_data;
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_tx_out  <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == C_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_state  <= ST_PARITY;
                            r_tx_out <= r_parity;
`else
                            r_state  <= ST_STOP;
                            r_tx_out <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + BIW'(1);
                            r_tx_out  <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state  <= ST_STOP;
                        r_tx_out <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_state  <= ST_IDLE;
                        r_tx_out <= 1'b1;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tx_out <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign tx_out   = r_tx_out;
    assign done     = r_done;

endmodule
`default_nettype wire
